song_reader: RTL and testbench
==============================

# song_reader

Sequencer that walks one 32-entry song in the 128-entry song ROM and turns each 16-bit entry into note-start events for the note players. It sits between the song ROM, which it addresses and reads, and the note-player voices, which it drives. It also takes the global beat pulse from the beat generator. Chord notes (advance flag 0) are issued back-to-back. Time-advance entries (flag 1) hold the reader for their duration in beats.

## Interface
- `VOICES`, default 3: number of note-player voices; must be 2..4.
- `IDX_W`, default 5: entry-index width; 2^IDX_W entries per song.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `play`  in  1: level; 1 = run, 0 = pause.
- `song`  in  2: song select; ROM address = {song_q, idx}.
- `beat`  in  1: single-cycle pulse, one per beat (48 Hz).
- `voice_busy`  in  VOICES: per-voice "note sounding" flags from the note players.
- `rom_addr`  out  7: combinational {song_q, idx} to the song ROM.
- `rom_dout`  in  16: ROM data; valid one cycle after `rom_addr` changes.
- `new_note`  out  1: one-cycle pulse; note-start strobe.
- `note`  out  6: note number; valid with `new_note`.
- `duration`  out  6: note length in beats; valid with `new_note`.
- `voice`  out  2: target voice index; valid with `new_note`.
- `song_done`  out  1: one-cycle pulse after the last entry completes.
- `busy`  out  1: 1 whenever the state is not IDLE.

## Operation
- Entry fields:
  - [15] `adv`.
  - [14:9] `note`.
  - [8:3] `dur`.
  - [2:0] metadata, which is ignored.
- States:
  - IDLE: `play`=1 latches `song` into song_q, sets idx=0, goes to FETCH.
  - FETCH: waits one cycle for ROM latency, then goes to DECODE.
  - DECODE: evaluates `rom_dout`.
    - `adv`=0 and note≠0: issue the note, then NEXT.
    - `adv`=0 and note=0: NEXT with no pulse.
    - `adv`=1 and dur=0: NEXT.
    - `adv`=1 and dur≠0: load beat_cnt=dur, go to WAIT.
  - WAIT: on each `beat`, beat_cnt decrements. A `beat` seen with beat_cnt=1 performs NEXT.
  - NEXT: if idx=2^IDX_W−1, pulse `song_done`, clear idx to 0, go to IDLE. Otherwise idx+1, go to FETCH. NEXT is an action taken on the DECODE/WAIT exit edge, not a state.
- Voice allocation:
  - Take the lowest-index voice that is free in (voice_busy | claimed_q).
  - claimed_q is a one-hot of the voice issued in the previous cycle. It covers the one-cycle rise latency of `voice_busy`.
  - If all voices are busy, steal voice 0.
- Pause: with `play`=0 in FETCH, DECODE or WAIT:
  - The state is held.
  - `beat` is ignored.
  - `new_note` is suppressed.
  - idx and beat_cnt are frozen.
  - Resume continues exactly where it stopped.
- Song change: if `song` ≠ song_q while not in IDLE, abort to IDLE with idx=0 and no `song_done`. If `play`=1, the next cycle restarts on the new song.
- Simultaneous `beat` and reset: reset wins.
- Reset mid-WAIT clears beat_cnt. No pulse is emitted.

## Timing
- Reset values: state IDLE, idx 0, song_q 0, `rom_addr` 0, `new_note` 0, `note` 0, `duration` 0, `voice` 0, `song_done` 0, `busy` 0, claimed_q 0.
- Outputs are registered, except `rom_addr` and `busy`.
- `new_note`, `note`, `duration` and `voice` assert the cycle after DECODE.
- Chord entries issue one note per 2 cycles (FETCH + DECODE).
- `play` rising in IDLE:
  - `rom_addr` is valid in the same cycle.
  - The first `new_note` appears 3 cycles later.
- A time-advance of dur=N exits on the Nth accepted `beat`. The next FETCH is the following cycle.
- `song_done` asserts one cycle after the final NEXT. `busy` is 0 in that same cycle.

## Structure
- Shared package `song_pkg`:
  - Entry field positions: ADV_BIT=15, NOTE_MSB/LSB=14/9, DUR_MSB/LSB=8/3.
  - Widths: NOTE_W=6, DUR_W=6.
  - State encoding localparams.
  - The same package is used by `song_rom` and the note player.
- Sub-module `voice_alloc`: combinational priority picker over (voice_busy | claimed_q). Outputs a voice index and an all-busy flag.

## Test plan
- Reset, then `play`=1 with song=0 and a ROM model with entry0={0,28,48}:
  - `rom_addr`=0.
  - `new_note` pulses 3 cycles after play, with note=28, duration=48, voice=0.
- Chord {0,28},{0,40},{0,52},{1,0,16} with voice_busy following issues:
  - Voices 0, 1, 2 are issued in that order on cycles 2 apart.
  - The reader then holds until exactly 16 beats.
  - Next `rom_addr`=4.
- All voices busy (voice_busy=3'b111) on a note entry: `new_note` with voice=0.
- Drop `play` in WAIT after 5 of 16 beats, send 10 beats, then re-raise `play`:
  - No progress while paused.
  - Exits after 11 further beats.
- song=3, run to idx 31 with all entries {1,0,1}:
  - `rom_addr` goes 96..127.
  - `song_done` pulses once.
  - `busy`=0.
- Change `song` from 1 to 2 mid-WAIT:
  - Abort with no `song_done`.
  - Restarts at `rom_addr`=64.
  - Reset asserted mid-note clears all outputs asynchronously.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared song-entry layout, field widths and sequencer state encoding.
// Used by the song reader, the song ROM and the note players.
package song_pkg;
  localparam int ADV_BIT  = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int ENTRY_W  = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_WAIT   = ST_WAIT
  } state_e;

  // Packed in ROM bit order: adv[15], note[14:9], dur[8:3], meta[2:0].
  typedef struct packed {
    logic              adv;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
    logic [2:0]        meta;
  } entry_t;
endpackage

// File: rtl/song_reader_if.sv
// Song reader bus: ROM port, transport controls and note-start events.
interface song_reader_if #(
  parameter int VOICES = 3,
  parameter int IDX_W  = 5
) ();
  logic                        play;
  logic [1:0]                  song;
  logic                        beat;
  logic [VOICES-1:0]           voice_busy;
  logic [IDX_W+1:0]            rom_addr;
  logic [song_pkg::ENTRY_W-1:0] rom_dout;
  logic                        new_note;
  logic [song_pkg::NOTE_W-1:0] note;
  logic [song_pkg::DUR_W-1:0]  duration;
  logic [1:0]                  voice;
  logic                        song_done;
  logic                        busy;

  modport master (
    input  play, song, beat, voice_busy, rom_dout,
    output rom_addr, new_note, note, duration, voice, song_done, busy
  );
  modport slave (
    output play, song, beat, voice_busy, rom_dout,
    input  rom_addr, new_note, note, duration, voice, song_done, busy
  );
endinterface

// File: rtl/song_reader_voice_alloc.sv
// Priority picker: lowest-index voice not marked taken, plus an all-taken flag.
module voice_alloc #(
  parameter int VOICES = 3
) (
  input  logic [VOICES-1:0] taken,
  output logic [1:0]        voice,
  output logic              all_busy
);
  always_comb begin
    voice    = '0;
    all_busy = 1'b1;
    // Walk downward so the lowest free index is the last one written.
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (!taken[v]) begin
        voice    = 2'(v);
        all_busy = 1'b0;
      end
    end
  end
endmodule

// File: rtl/song_reader.sv
// Walks one song in the song ROM, issuing chord notes back-to-back and
// holding on time-advance entries for their length in beats.
module song_reader
  import song_pkg::*;
#(
  parameter int VOICES = 3,
  parameter int IDX_W  = 5
) (
  input logic            clk,
  input logic            reset,
  song_reader_if.master  bus
);
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        song_q, song_d;
  logic [DUR_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              new_note_q, new_note_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [1:0]        voice_q, voice_d;
  logic              song_done_q, song_done_d;
  logic [VOICES-1:0] claimed_q, claimed_d;

  entry_t            ent;
  logic              unused_meta;
  logic [1:0]        pick;
  logic              all_busy;
  logic              advance;

  assign ent         = entry_t'(bus.rom_dout);
  assign unused_meta = ^ent.meta;

  voice_alloc #(.VOICES(VOICES)) u_alloc (
    .taken    (bus.voice_busy | claimed_q),
    .voice    (pick),
    .all_busy (all_busy)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    song_d      = song_q;
    beat_cnt_d  = beat_cnt_q;
    new_note_d  = 1'b0;
    note_d      = note_q;
    dur_d       = dur_q;
    voice_d     = voice_q;
    song_done_d = 1'b0;
    advance     = 1'b0;
    // Shadow the voice just strobed until its busy flag has had time to rise.
    claimed_d   = new_note_q ? ({{(VOICES-1){1'b0}}, 1'b1} << voice_q) : '0;

    if (state_q == S_IDLE) begin
      if (bus.play) begin
        song_d  = bus.song;
        idx_d   = '0;
        state_d = S_FETCH;
      end
    end else if (bus.song != song_q) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      beat_cnt_d = '0;
    end else if (bus.play) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          if (!ent.adv) begin
            if (ent.note != '0) begin
              new_note_d = 1'b1;
              note_d     = ent.note;
              dur_d      = ent.dur;
              voice_d    = all_busy ? 2'd0 : pick;
            end
            advance = 1'b1;
          end else if (ent.dur == '0) begin
            advance = 1'b1;
          end else begin
            beat_cnt_d = ent.dur;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.beat) begin
            beat_cnt_d = beat_cnt_q - 1'b1;
            advance    = (beat_cnt_q == DUR_W'(1));
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (advance) begin
      if (idx_q == '1) begin
        song_done_d = 1'b1;
        idx_d       = '0;
        state_d     = S_IDLE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      beat_cnt_q  <= '0;
      new_note_q  <= 1'b0;
      note_q      <= '0;
      dur_q       <= '0;
      voice_q     <= '0;
      song_done_q <= 1'b0;
      claimed_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_q      <= song_d;
      beat_cnt_q  <= beat_cnt_d;
      new_note_q  <= new_note_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      voice_q     <= voice_d;
      song_done_q <= song_done_d;
      claimed_q   <= claimed_d;
    end
  end

  // In IDLE the address follows the live song select so play's first fetch is ready at once.
  assign bus.rom_addr  = (state_q == S_IDLE) ? {bus.song, idx_q} : {song_q, idx_q};
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.new_note  = new_note_q;
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.voice     = voice_q;
  assign bus.song_done = song_done_q;
endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: registered ROM model, follow-the-issues voice_busy
// model and per-scenario tasks checked against expectations from the entry rules.
module tb_song_reader;
  import song_pkg::*;
  localparam int VOICES = 3;
  localparam int IDX_W  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  song_reader_if #(.VOICES(VOICES), .IDX_W(IDX_W)) bus ();
  song_reader #(.VOICES(VOICES), .IDX_W(IDX_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] rom [128];
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  // Note players: a voice reads busy from the cycle after its strobe.
  logic [VOICES-1:0] vb_follow = '0;
  logic              vb_clr = 1'b1;
  logic              force_en = 1'b0;
  logic [VOICES-1:0] force_val = '0;
  always @(posedge clk)
    if (vb_clr) vb_follow <= '0;
    else if (bus.new_note) vb_follow <= vb_follow | (VOICES'(1) << bus.voice);
  assign bus.voice_busy = force_en ? force_val : vb_follow;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] mk(input logic adv, input int nt, input int du);
    return {adv, 6'(nt), 6'(du), 3'($urandom)};
  endfunction

  function automatic logic [1:0] lowest_free(input logic [VOICES-1:0] b);
    for (int v = 0; v < VOICES; v++) if (!b[v]) return 2'(v);
    return 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat();
    bus.beat = 1'b1; tick(); bus.beat = 1'b0; tick();
  endtask

  task automatic park_rom();
    for (int i = 0; i < 128; i++) rom[i] = mk(1'b1, 0, 63);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.play = 1'b0; bus.beat = 1'b0; bus.song = 2'd0;
    force_en = 1'b0; vb_clr = 1'b1;
    tick(); tick();
    reset = 1'b0; vb_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.play = 1'b0; bus.beat = 1'b0; bus.song = 2'd0; park_rom();
    tick();
    n_cmp++; if (bus.rom_addr !== 7'd0) begin n_bad++; $display("FAIL reset.rom_addr got %0d want 0", bus.rom_addr); end
    n_cmp++; if (bus.new_note !== 1'b0) begin n_bad++; $display("FAIL reset.new_note got %b want 0", bus.new_note); end
    n_cmp++; if (bus.note !== 6'd0) begin n_bad++; $display("FAIL reset.note got %0d want 0", bus.note); end
    n_cmp++; if (bus.duration !== 6'd0) begin n_bad++; $display("FAIL reset.duration got %0d want 0", bus.duration); end
    n_cmp++; if (bus.voice !== 2'd0) begin n_bad++; $display("FAIL reset.voice got %0d want 0", bus.voice); end
    n_cmp++; if (bus.song_done !== 1'b0) begin n_bad++; $display("FAIL reset.song_done got %b want 0", bus.song_done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy got %b want 0", bus.busy); end
    reset = 1'b0; vb_clr = 1'b0; tick();
  endtask

  task automatic test_first_note();
    int n;
    do_reset(); park_rom();
    rom[0] = mk(1'b0, 28, 48);
    bus.song = 2'd0; bus.play = 1'b1; #1;
    n_cmp++; if (bus.rom_addr !== 7'd0) begin n_bad++; $display("FAIL first.rom_addr got %0d want 0", bus.rom_addr); end
    n = 0;
    while (!bus.new_note && n < 8) begin tick(); n++; end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL first.latency got %0d want 3", n); end
    n_cmp++; if ({bus.note, bus.duration, bus.voice} !== {6'd28, 6'd48, 2'd0})
      begin n_bad++; $display("FAIL first.fields got n%0d d%0d v%0d want n28 d48 v0", bus.note, bus.duration, bus.voice); end
  endtask

  task automatic test_chord();
    for (int it = 0; it < 3; it++) begin
      int s, k, w, n, base, nn;
      int nt [3];
      int du [3];
      logic [VOICES-1:0] model_busy;
      do_reset(); park_rom();
      s = $urandom_range(0, 3); base = s * 32;
      k = (it == 0) ? 3 : $urandom_range(1, 3);
      w = (it == 0) ? 16 : $urandom_range(2, 20);
      for (int j = 0; j < k; j++) begin
        nt[j] = $urandom_range(1, 63); du[j] = $urandom_range(0, 63);
        rom[base + j] = mk(1'b0, nt[j], du[j]);
      end
      rom[base + k] = mk(1'b1, 0, w);
      model_busy = '0;
      bus.song = 2'(s); bus.play = 1'b1;
      for (int j = 0; j < k; j++) begin
        logic [1:0] ev;
        ev = lowest_free(model_busy);
        n = 0;
        do begin tick(); n++; end while (!bus.new_note && n < 8);
        n_cmp++; if (n !== ((j == 0) ? 3 : 2)) begin n_bad++; $display("FAIL chord.gap[%0d] got %0d want %0d", j, n, (j == 0) ? 3 : 2); end
        n_cmp++; if ({bus.note, bus.duration, bus.voice} !== {6'(nt[j]), 6'(du[j]), ev})
          begin n_bad++; $display("FAIL chord.fields[%0d] got n%0d d%0d v%0d want n%0d d%0d v%0d", j, bus.note, bus.duration, bus.voice, nt[j], du[j], ev); end
        model_busy[ev] = 1'b1;
      end
      repeat (3) tick();
      n_cmp++; if (bus.busy !== 1'b1 || bus.rom_addr !== 7'(base + k))
        begin n_bad++; $display("FAIL chord.wait_entry got busy%b addr%0d want busy1 addr%0d", bus.busy, bus.rom_addr, base + k); end
      nn = 0;
      for (int b = 1; b <= w; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        bus.beat = 1'b1; tick(); bus.beat = 1'b0;
        if (bus.new_note) nn++;
        n_cmp++; if (bus.rom_addr !== 7'(base + k + ((b == w) ? 1 : 0)))
          begin n_bad++; $display("FAIL chord.beat[%0d/%0d] addr got %0d want %0d", b, w, bus.rom_addr, base + k + ((b == w) ? 1 : 0)); end
      end
      n_cmp++; if (nn !== 0) begin n_bad++; $display("FAIL chord.wait_notes got %0d want 0", nn); end
    end
  endtask

  task automatic test_all_busy();
    for (int it = 0; it < 6; it++) begin
      int s, n, nt;
      logic [1:0] ev;
      do_reset(); park_rom();
      force_en = 1'b1;
      force_val = (it == 0) ? 3'b111 : VOICES'($urandom);
      ev = lowest_free(force_val);
      s = $urandom_range(0, 3); nt = $urandom_range(1, 63);
      rom[s * 32] = mk(1'b0, nt, $urandom_range(0, 63));
      bus.song = 2'(s); bus.play = 1'b1;
      n = 0;
      while (!bus.new_note && n < 8) begin tick(); n++; end
      n_cmp++; if (bus.new_note !== 1'b1 || bus.voice !== ev || bus.note !== 6'(nt))
        begin n_bad++; $display("FAIL alloc[%b] got nn%b v%0d n%0d want nn1 v%0d n%0d", force_val, bus.new_note, bus.voice, bus.note, ev, nt); end
    end
    force_en = 1'b0;
  endtask

  task automatic test_pause_fetch();
    int s, nt, r, nn;
    do_reset(); park_rom();
    s = $urandom_range(0, 3); nt = $urandom_range(1, 63); r = $urandom_range(1, 6);
    rom[s * 32] = mk(1'b0, nt, 5);
    bus.song = 2'(s); bus.play = 1'b1;
    tick();
    bus.play = 1'b0; nn = 0;
    repeat (r) begin tick(); if (bus.new_note) nn++; end
    n_cmp++; if (nn !== 0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL pause_fetch.held got notes%0d busy%b want notes0 busy1", nn, bus.busy); end
    bus.play = 1'b1; tick(); tick();
    n_cmp++; if (bus.new_note !== 1'b1 || bus.note !== 6'(nt))
      begin n_bad++; $display("FAIL pause_fetch.resume got nn%b n%0d want nn1 n%0d", bus.new_note, bus.note, nt); end
  endtask

  task automatic test_pause_wait();
    int s, base;
    do_reset(); park_rom();
    s = $urandom_range(0, 3); base = s * 32;
    rom[base] = mk(1'b1, 0, 16);
    bus.song = 2'(s); bus.play = 1'b1;
    repeat (4) tick();
    repeat (5) send_beat();
    bus.play = 1'b0;
    repeat (10) send_beat();
    n_cmp++; if (bus.rom_addr !== 7'(base) || bus.busy !== 1'b1)
      begin n_bad++; $display("FAIL pause_wait.held got addr%0d busy%b want addr%0d busy1", bus.rom_addr, bus.busy, base); end
    bus.play = 1'b1;
    repeat (10) send_beat();
    n_cmp++; if (bus.rom_addr !== 7'(base)) begin n_bad++; $display("FAIL pause_wait.10 addr got %0d want %0d", bus.rom_addr, base); end
    send_beat();
    n_cmp++; if (bus.rom_addr !== 7'(base + 1)) begin n_bad++; $display("FAIL pause_wait.11 addr got %0d want %0d", bus.rom_addr, base + 1); end
  endtask

  task automatic test_song_done();
    int prev, bad, done_cnt, cyc;
    logic busy_at_done;
    do_reset(); park_rom();
    for (int i = 96; i < 128; i++) rom[i] = mk(1'b1, 0, 1);
    bus.song = 2'd3; bus.play = 1'b1; bus.beat = 1'b1; #1;
    prev = bus.rom_addr; bad = 0; done_cnt = 0; cyc = 0; busy_at_done = 1'b1;
    while (done_cnt == 0 && cyc < 300) begin
      tick(); cyc++;
      if (bus.song_done) begin
        done_cnt++; busy_at_done = bus.busy; bus.play = 1'b0; bus.beat = 1'b0;
      end else if (bus.rom_addr != 7'(prev)) begin
        if (bus.rom_addr != 7'(prev + 1)) bad++;
        prev = bus.rom_addr;
      end
    end
    repeat (5) begin tick(); if (bus.song_done) done_cnt++; end
    n_cmp++; if (bad !== 0 || prev !== 127) begin n_bad++; $display("FAIL done.addr_walk got bad%0d last%0d want bad0 last127", bad, prev); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL done.pulses got %0d want 1", done_cnt); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL done.busy got %b want 0", busy_at_done); end
  endtask

  task automatic test_song_change();
    int nt, du, n, dn;
    do_reset(); park_rom();
    nt = $urandom_range(1, 63); du = $urandom_range(1, 63);
    rom[32] = mk(1'b1, 0, 16);
    rom[64] = mk(1'b0, nt, du);
    bus.song = 2'd1; bus.play = 1'b1;
    repeat (4) tick();
    repeat ($urandom_range(1, 10)) send_beat();
    n_cmp++; if (bus.rom_addr !== 7'd32 || bus.busy !== 1'b1)
      begin n_bad++; $display("FAIL change.pre got addr%0d busy%b want addr32 busy1", bus.rom_addr, bus.busy); end
    bus.song = 2'd2; tick();
    n_cmp++; if ({bus.busy, bus.song_done, bus.rom_addr} !== {1'b0, 1'b0, 7'd64})
      begin n_bad++; $display("FAIL change.abort got busy%b done%b addr%0d want busy0 done0 addr64", bus.busy, bus.song_done, bus.rom_addr); end
    n = 0; dn = 0;
    while (!bus.new_note && n < 8) begin tick(); n++; if (bus.song_done) dn++; end
    n_cmp++; if (n !== 3 || dn !== 0 || bus.note !== 6'(nt))
      begin n_bad++; $display("FAIL change.restart got lat%0d done%0d n%0d want lat3 done0 n%0d", n, dn, bus.note, nt); end
    // Asynchronous reset while the note strobe is up, away from any clock edge.
    #2 reset = 1'b1; bus.song = 2'd0; #1;
    n_cmp++; if ({bus.new_note, bus.note, bus.duration, bus.voice, bus.song_done, bus.busy, bus.rom_addr} !== '0)
      begin n_bad++; $display("FAIL change.async_reset got nn%b n%0d d%0d v%0d done%b busy%b addr%0d want all 0",
        bus.new_note, bus.note, bus.duration, bus.voice, bus.song_done, bus.busy, bus.rom_addr); end
    tick(); reset = 1'b0; bus.play = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    bus.play = 1'b0; bus.beat = 1'b0; bus.song = 2'd0;
    test_reset();
    test_first_note();
    test_chord();
    test_all_busy();
    test_pause_fetch();
    test_pause_wait();
    test_song_done();
    test_song_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
